// File: rtl/seq_pkg.sv
// Shared encodings for the ALU control sequencer: opcodes, ALU commands,
// controller states and the halt instruction word.
package seq_pkg;

    typedef enum logic [2:0] {
        OP_ADD   = 3'b000,
        OP_LSL   = 3'b001,
        OP_MOVF  = 3'b010,
        OP_XOR   = 3'b011,
        OP_MOV   = 3'b100,
        OP_LSR   = 3'b101,
        OP_SUB   = 3'b110,
        OP_CMPBF = 3'b111
    } opcode_e;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_LSL  = 3'b001;
    localparam logic [2:0] ALU_MOVF = 3'b010;
    localparam logic [2:0] ALU_XOR  = 3'b011;
    localparam logic [2:0] ALU_MOV  = 3'b100;
    localparam logic [2:0] ALU_LSR  = 3'b101;
    localparam logic [2:0] ALU_SUB  = 3'b110;
    localparam logic [2:0] ALU_CMP  = 3'b111;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_EXEC  = 3'd2,
        ST_WB    = 3'd3,
        ST_HALT  = 3'd4
    } state_e;

    localparam logic [8:0] HALT_WORD = 9'h1E0;

endpackage

// File: rtl/instr_decode.sv
// Combinational decode of a 9-bit instruction word into ALU command and
// write-back controls.
module instr_decode
    import seq_pkg::*;
(
    input  logic [8:0] i_ir,
    output logic [2:0] o_alu_cmd,
    output logic       o_b_imm,
    output logic       o_acc_we,
    output logic       o_rf_we,
    output logic       o_flag_we,
    output logic       o_is_branch,
    output logic       o_is_halt
);

    // Opcode/mode to control-strobe mapping.
    always_comb begin
        o_alu_cmd   = ALU_ADD;
        o_b_imm     = 1'b0;
        o_acc_we    = 1'b0;
        o_rf_we     = 1'b0;
        o_flag_we   = 1'b0;
        o_is_branch = 1'b0;
        o_is_halt   = 1'b0;
        case (i_ir[8:6])
            OP_ADD, OP_XOR, OP_LSR: begin
                o_alu_cmd = i_ir[8:6];
                o_acc_we  = 1'b1;
            end
            OP_LSL, OP_SUB: begin
                o_alu_cmd = i_ir[8:6];
                o_acc_we  = 1'b1;
                o_flag_we = 1'b1;
            end
            OP_MOVF: begin
                o_alu_cmd = ALU_MOVF;
                o_rf_we   = 1'b1;
            end
            OP_MOV: begin
                o_alu_cmd = ALU_MOV;
                o_acc_we  = 1'b1;
                o_b_imm   = i_ir[5];
            end
            OP_CMPBF: begin
                if (i_ir[5]) begin
                    o_is_branch = 1'b1;
                    o_is_halt   = (i_ir[4:0] == 5'd0);
                end else begin
                    o_alu_cmd = ALU_CMP;
                    o_flag_we = 1'b1;
                end
            end
            default: begin
                o_alu_cmd = ALU_ADD;
            end
        endcase
    end

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle FETCH/EXEC/WB controller that drives a combinational 8-bit ALU
// and retires results to the accumulator, register file and PC.
module alu_sequencer
    import seq_pkg::*;
#(
    parameter int PC_W  = 8,
    parameter int RF_AW = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic             imem_req,
    output logic [PC_W-1:0]  imem_addr,
    input  logic             imem_valid,
    input  logic [8:0]       imem_data,
    output logic [RF_AW-1:0] rf_raddr,
    input  logic [7:0]       rf_rdata,
    output logic             rf_we,
    output logic [RF_AW-1:0] rf_waddr,
    output logic [7:0]       rf_wdata,
    output logic [2:0]       alu_cmd,
    output logic [7:0]       alu_a,
    output logic [7:0]       alu_b,
    input  logic [7:0]       alu_rslt,
    input  logic             alu_flag,
    output logic             busy,
    output logic             done
);

    state_e          r_state;
    state_e          w_next_state;
    logic [PC_W-1:0] r_pc;
    logic [7:0]      r_acc;
    logic            r_flag;
    logic [8:0]      r_ir;
    logic [7:0]      r_rslt;
    logic            r_aflag;

    logic [2:0]      w_alu_cmd;
    logic            w_b_imm;
    logic            w_acc_we;
    logic            w_rf_we;
    logic            w_flag_we;
    logic            w_is_branch;
    logic            w_is_halt;
    logic [PC_W-1:0] w_br_off;
    logic [PC_W-1:0] w_pc_inc;

    instr_decode u_decode (
        .i_ir        (r_ir),
        .o_alu_cmd   (w_alu_cmd),
        .o_b_imm     (w_b_imm),
        .o_acc_we    (w_acc_we),
        .o_rf_we     (w_rf_we),
        .o_flag_we   (w_flag_we),
        .o_is_branch (w_is_branch),
        .o_is_halt   (w_is_halt)
    );

    assign w_br_off = {{(PC_W-5){r_ir[4]}}, r_ir[4:0]};
    assign w_pc_inc = r_pc + {{(PC_W-1){1'b0}}, 1'b1};

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:  if (start) w_next_state = ST_FETCH; else w_next_state = ST_IDLE;
            ST_FETCH: if (imem_valid) w_next_state = ST_EXEC; else w_next_state = ST_FETCH;
            ST_EXEC:  w_next_state = ST_WB;
            ST_WB:    if (w_is_halt) w_next_state = ST_HALT; else w_next_state = ST_FETCH;
            ST_HALT:  if (start) w_next_state = ST_IDLE; else w_next_state = ST_HALT;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    // Architectural registers: IR capture, ALU result latch and WB retirement.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc    <= '0;
            r_acc   <= 8'h00;
            r_flag  <= 1'b0;
            r_ir    <= 9'h000;
            r_rslt  <= 8'h00;
            r_aflag <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) r_pc <= '0;
                end
                ST_FETCH: begin
                    if (imem_valid) r_ir <= imem_data;
                end
                ST_EXEC: begin
                    r_rslt  <= alu_rslt;
                    r_aflag <= alu_flag;
                end
                ST_WB: begin
                    if (w_acc_we)  r_acc  <= r_rslt;
                    if (w_flag_we) r_flag <= r_aflag;
                    // Branch tests the flag as it stood before this instruction.
                    if (!w_is_halt) begin
                        if (w_is_branch && r_flag) r_pc <= r_pc + w_br_off;
                        else                       r_pc <= w_pc_inc;
                    end
                end
                ST_HALT: begin
                    if (start) begin
                        r_pc   <= '0;
                        r_acc  <= 8'h00;
                        r_flag <= 1'b0;
                    end
                end
                default: begin
                    r_pc <= r_pc;
                end
            endcase
        end
    end

    // Outputs decoded from the current state.
    always_comb begin
        imem_req = 1'b0;
        alu_cmd  = 3'b000;
        alu_b    = 8'h00;
        rf_we    = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                busy = 1'b0;
            end
            ST_FETCH: begin
                imem_req = 1'b1;
                busy     = 1'b1;
            end
            ST_EXEC: begin
                busy    = 1'b1;
                alu_cmd = w_alu_cmd;
                if (w_is_branch)  alu_b = 8'h00;
                else if (w_b_imm) alu_b = {3'b000, r_ir[4:0]};
                else              alu_b = rf_rdata;
            end
            ST_WB: begin
                busy  = 1'b1;
                rf_we = w_rf_we;
            end
            ST_HALT: begin
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    assign imem_addr = r_pc;
    assign rf_raddr  = r_ir[RF_AW-1:0];
    assign rf_waddr  = r_ir[RF_AW-1:0];
    assign rf_wdata  = r_rslt;
    assign alu_a     = r_acc;

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Multi-cycle control sequencer driving the 8-bit datapath ALU: fetches 9-bit instructions from instruction memory over a valid/request handshake, decodes them into `alu_cmd`/operands, captures `rslt`/`flag`, and retires results to the accumulator, register file and PC. It is the producer side of the ALU interface and sits between instruction memory, the register file and the combinational ALU.

## Interface
- `PC_W`, 8, program counter width; PC wraps modulo 2^PC_W.
- `RF_AW`, 4, register file address width (16 registers).
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high; one clock, async active-high reset.
- `start`  in  1  pulse in IDLE begins execution at PC=0.
- `imem_req`  out  1  fetch request, held until `imem_valid`.
- `imem_addr`  out  PC_W  fetch address (= PC).
- `imem_valid`  in  1  instruction word valid this cycle.
- `imem_data`  in  9  instruction word.
- `rf_raddr`  out  RF_AW  = IR[3:0].
- `rf_rdata`  in  8  combinational read data.
- `rf_we`  out  1  register write strobe (one cycle).
- `rf_waddr`  out  RF_AW  = IR[3:0].
- `rf_wdata`  out  8  write data.
- `alu_cmd`  out  3  ALU opcode.
- `alu_a`  out  8  ALU inA (accumulator).
- `alu_b`  out  8  ALU inB (R[rs] or zero-extended imm5).
- `alu_rslt`  in  8  ALU result.
- `alu_flag`  in  1  ALU flag.
- `busy`  out  1  high outside IDLE/HALT.
- `done`  out  1  high in HALT.

## Operation
- Format: IR[8:6] opcode, IR[5] mode, IR[4:0] operand/imm.
- 000 ADD, 001 LSL, 011 XOR, 101 LSR, 110 SUB: acc ← rslt; alu_cmd = opcode; alu_b = R[IR[3:0]].
- 010 MOVF: R[IR[3:0]] ← acc (alu_cmd 010, rslt passes inA).
- 100 MOVT (IR[5]=0): acc ← R[rs]; MOVI (IR[5]=1): acc ← {3'b0, IR[4:0]}; alu_cmd 100.
- 111 IR[5]=0 CMP: alu_cmd 111; no acc/RF write.
- 111 IR[5]=1 BF: IR[4:0]=0 → HALT; else if flag_q, PC ← PC + sext(IR[4:0]) mod 2^PC_W, otherwise PC+1. No ALU use (alu_cmd 000).
- flag_q updated from `alu_flag` only by LSL, SUB, CMP; held by all others.
- Non-branch: PC ← PC+1, 2^PC_W−1 wraps to 0.
- States: IDLE → (start) FETCH → (imem_valid) EXEC → WB → FETCH; WB of HALT instruction → HALT. HALT → IDLE on `start` (PC, acc, flag_q cleared).
- `start` outside IDLE/HALT ignored; `imem_valid` outside FETCH ignored.

## Timing
- Reset: state IDLE, PC=0, acc=0, flag_q=0, IR=0; all outputs 0 (`alu_a`=acc=0).
- FETCH: `imem_req`=1, `imem_addr`=PC registered; IR captured on cycle `imem_valid`=1 (same-cycle valid allowed, arbitrary wait).
- EXEC: ALU inputs driven from IR/acc/`rf_rdata`; `alu_rslt`/`alu_flag` registered at end of EXEC.
- WB: acc/`rf_we`/PC/flag_q update; `rf_we` exactly one cycle, in WB only.
- Minimum 3 cycles per instruction (valid in first FETCH cycle).
- Reset asserted mid-FETCH drops `imem_req` immediately; mid-WB suppresses write.

## Structure
- Package `seq_pkg`: opcode enum, ALU command localparams (ADD=000 … CMP=111), state enum, HALT encoding constant.
- Sub-module `instr_decode`: combinational IR → alu_cmd, b-select, acc_we, rf_we, flag_we, is_branch, is_halt.

## Test plan
- MOVI 5; MOVI→R1 via MOVF; MOVI 3; ADD R1 → acc=8, rf write R1=5 seen once in WB.
- MOVI 1; SUB R(=2) → acc=0xFF, flag_q=1; BF −2 taken → next imem_addr = PC−2.
- CMP unequal (flag 0) then BF +4 → not taken, imem_addr = PC+1.
- `imem_valid` delayed 5 cycles → `imem_req`/addr held stable, IR captured on valid only; spurious valid in EXEC ignored.
- PC at 0xFF, non-branch → next fetch address 0x00.
- HALT word 0x1E0 → `done`=1, `busy`=0; reset mid-FETCH → all outputs 0 asynchronously, restart from PC=0.
